// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arb (with helper module alu)
// Purpose  : Shares one combinational ALU between two valid/ready requesters.
//            Requester 0 is the integer pipeline and requester 1 is an
//            auxiliary unit. Requesters are granted round-robin. The granted
//            op is executed and returned as a registered response tagged
//            with the id of the requester that issued it.
// Ports    : clk, rst_n (synchronous, active-low)
//            req{0,1}_valid/_ready/_op/_src1/_src2 : requester handshakes
//            resp_valid/resp_ready                 : response handshake
//            resp_id/resp_res/resp_zero            : registered response
// Options  : ALU_ARB_FAST_EN - when defined, the ALU is fed directly from the
//            granted requester and the response is registered on the grant
//            edge (1-cycle latency, 1 op/cycle). When undefined, operands are
//            registered first (2-cycle latency, 1 op per 2 cycles).
// Op codes : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//            8 SLT, 9 SLTU; all other encodings give res=0, zero=0.
// Revision : 1.0 - initial release
// ============================================================================

module alu #(
    parameter int ALU_OP_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [DATA_W-1:0]   i_src1,
    input  logic [DATA_W-1:0]   i_src2,
    output logic [DATA_W-1:0]   o_res,
    output logic                o_zero
);
    localparam int c_shw = $clog2(DATA_W);

    localparam logic [ALU_OP_W-1:0] c_op_add  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] c_op_sub  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] c_op_and  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] c_op_or   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] c_op_xor  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] c_op_sll  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] c_op_srl  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] c_op_sra  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] c_op_slt  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] c_op_sltu = ALU_OP_W'(9);

    logic [c_shw-1:0]  w_shamt;
    logic [DATA_W-1:0] w_res;
    logic              w_known;
    logic              w_unused;

    assign w_shamt  = i_src2[c_shw-1:0];
    // Upper operand-2 bits are irrelevant to shifts but used by other ops.
    assign w_unused = ^i_src2[DATA_W-1:c_shw];

    always_comb begin
        w_res   = '0;
        w_known = 1'b1;
        case (i_op)
            c_op_add:  w_res = i_src1 + i_src2;
            c_op_sub:  w_res = i_src1 - i_src2;
            c_op_and:  w_res = i_src1 & i_src2;
            c_op_or:   w_res = i_src1 | i_src2;
            c_op_xor:  w_res = i_src1 ^ i_src2;
            c_op_sll:  w_res = i_src1 << w_shamt;
            c_op_srl:  w_res = i_src1 >> w_shamt;
            c_op_sra:  w_res = $unsigned($signed(i_src1) >>> w_shamt);
            c_op_slt:  w_res = {{(DATA_W-1){1'b0}}, $signed(i_src1) < $signed(i_src2)};
            c_op_sltu: w_res = {{(DATA_W-1){1'b0}}, i_src1 < i_src2};
            default:   w_known = 1'b0;
        endcase
    end

    assign o_res  = w_res;
    // ADD never reports zero; unknown ops report neither result nor zero.
    assign o_zero = w_known && (i_op != c_op_add) && (w_res == '0);
endmodule

module alu_share_arb #(
    parameter int ALU_OP_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic [DATA_W-1:0]   req0_src1,
    input  logic [DATA_W-1:0]   req0_src2,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ALU_OP_W-1:0] req1_op,
    input  logic [DATA_W-1:0]   req1_src1,
    input  logic [DATA_W-1:0]   req1_src2,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [DATA_W-1:0]   resp_res,
    output logic                resp_zero
);
    localparam logic [1:0] c_st_idle = 2'd0;
`ifndef ALU_ARB_FAST_EN
    localparam logic [1:0] c_st_exec = 2'd1;
`endif
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]          r_state;
    logic                r_rr;
    logic                w_accept;
    logic                w_grant;
    logic                w_gnt_id;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic [DATA_W-1:0]   w_alu_src1;
    logic [DATA_W-1:0]   w_alu_src2;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_zero;

`ifndef ALU_ARB_FAST_EN
    logic [ALU_OP_W-1:0] r_op;
    logic [DATA_W-1:0]   r_src1;
    logic [DATA_W-1:0]   r_src2;
    logic                r_id;
`endif

    // A new op may enter when idle, or when the held response leaves now.
    assign w_accept = (r_state == c_st_idle) || ((r_state == c_st_resp) && resp_ready);
    // Gate with rst_n so no ready is ever shown while reset is asserted.
    assign w_grant  = rst_n && w_accept && (req0_valid || req1_valid);
    // Requester 1 wins when it is alone, or when both ask and it is preferred.
    assign w_gnt_id = req1_valid && (!req0_valid || r_rr);

    assign req0_ready = w_grant && !w_gnt_id;
    assign req1_ready = w_grant &&  w_gnt_id;

`ifdef ALU_ARB_FAST_EN
    assign w_alu_op   = w_gnt_id ? req1_op   : req0_op;
    assign w_alu_src1 = w_gnt_id ? req1_src1 : req0_src1;
    assign w_alu_src2 = w_gnt_id ? req1_src2 : req0_src2;
`else
    assign w_alu_op   = r_op;
    assign w_alu_src1 = r_src1;
    assign w_alu_src2 = r_src2;
`endif

    alu #(
        .ALU_OP_W (ALU_OP_W),
        .DATA_W   (DATA_W)
    ) u_alu (
        .i_op   (w_alu_op),
        .i_src1 (w_alu_src1),
        .i_src2 (w_alu_src2),
        .o_res  (w_alu_res),
        .o_zero (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_rr       <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_res   <= '0;
            resp_zero  <= 1'b0;
`ifndef ALU_ARB_FAST_EN
            r_op       <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_id       <= 1'b0;
`endif
        end else begin
`ifdef ALU_ARB_FAST_EN
            if (w_grant) begin
                // Result registered on the grant edge; a grant while a
                // response leaves simply reloads and keeps resp_valid high.
                resp_res   <= w_alu_res;
                resp_zero  <= w_alu_zero;
                resp_id    <= w_gnt_id;
                resp_valid <= 1'b1;
                r_rr       <= ~w_gnt_id;
                r_state    <= c_st_resp;
            end else if ((r_state == c_st_resp) && resp_ready) begin
                resp_valid <= 1'b0;
                r_state    <= c_st_idle;
            end else if (r_state != c_st_resp) begin
                r_state    <= c_st_idle;
            end
`else
            case (r_state)
                c_st_idle: ;
                c_st_exec: begin
                    resp_res   <= w_alu_res;
                    resp_zero  <= w_alu_zero;
                    resp_id    <= r_id;
                    resp_valid <= 1'b1;
                    r_state    <= c_st_resp;
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
            // A grant (only possible in IDLE or a draining RESP) overrides
            // the next-state chosen above.
            if (w_grant) begin
                r_op    <= w_gnt_id ? req1_op   : req0_op;
                r_src1  <= w_gnt_id ? req1_src1 : req0_src1;
                r_src2  <= w_gnt_id ? req1_src2 : req0_src2;
                r_id    <= w_gnt_id;
                r_rr    <= ~w_gnt_id;
                r_state <= c_st_exec;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arb
// Purpose  : Self-checking bench for alu_share_arb. A reference model predicts
//            grants and queues expected responses; a monitor compares every
//            presented response against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4, OP_SRA = 4'd7, OP_SLTU = 4'd9, OP_BAD = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic        resp_valid, resp_ready, resp_id, resp_zero;
    logic [31:0] resp_res;

    always #5 clk = ~clk;

    alu_share_arb #(.ALU_OP_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_res(resp_res), .resp_zero(resp_zero)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU from the op definitions: returns {zero, res}.
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int          sh;
        logic        known;
        sh = int'(b[4:0]);
        r = 32'd0;
        known = 1'b1;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: known = 1'b0;
        endcase
        return {known && (op != 4'd0) && (r == 32'd0), r};
    endfunction

    // Model state: expected queue {id, zero, res}, rr preference, and whether
    // a response is (will be) presented or an op is still executing.
    logic [33:0] q[$];
    logic        m_rr = 1'b0, m_pend = 1'b0, m_exec = 1'b0, m_in_reset = 1'b0;

    always @(negedge clk) begin
        logic acc, gv, g;
        logic [33:0] e;
        if (!rst_n) begin
            if (m_in_reset) begin
                chk("rst_resp_valid", 32'(resp_valid), 32'd0);
                chk("rst_resp_res", resp_res, 32'd0);
                chk("rst_resp_zero", 32'(resp_zero), 32'd0);
                chk("rst_resp_id", 32'(resp_id), 32'd0);
            end
            chk("rst_req0_ready", 32'(req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(req1_ready), 32'd0);
            m_rr = 1'b0; m_pend = 1'b0; m_exec = 1'b0; m_in_reset = 1'b1;
            q.delete();
        end else begin
            m_in_reset = 1'b0;
            chk("resp_valid", 32'(resp_valid), 32'(m_pend));
            if (resp_valid && m_pend) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", 32'(resp_valid), 32'd0);
                end else begin
                    e = q[0];
                    chk("resp_id", 32'(resp_id), 32'(e[33]));
                    chk("resp_zero", 32'(resp_zero), 32'(e[32]));
                    chk("resp_res", resp_res, e[31:0]);
                end
            end
            if (m_pend && resp_ready && q.size() > 0) void'(q.pop_front());
            acc = !m_exec && (!m_pend || resp_ready);
            gv  = acc && (req0_valid || req1_valid);
            g   = (req0_valid && req1_valid) ? m_rr : req1_valid;
            chk("req0_ready", 32'(req0_ready), 32'(gv && !g));
            chk("req1_ready", 32'(req1_ready), 32'(gv && g));
            if (gv) begin
                if (g) q.push_back({1'b1, ref_alu(req1_op, req1_src1, req1_src2)});
                else   q.push_back({1'b0, ref_alu(req0_op, req0_src1, req0_src2)});
                m_rr = ~g;
            end
`ifdef ALU_ARB_FAST_EN
            m_pend = gv || (m_pend && !resp_ready);
`else
            m_pend = m_exec || (m_pend && !resp_ready);
            m_exec = gv;
`endif
        end
    end

    task automatic send0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got = 1'b0;
        req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req0_ready) begin got = 1'b1; break; end
        end
        chk("req0_grant_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req0_op = 4'($urandom); req0_src1 = $urandom; req0_src2 = $urandom;
    endtask

    task automatic send1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got = 1'b0;
        req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req1_ready) begin got = 1'b1; break; end
        end
        chk("req1_grant_wait", 32'(got), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0; req1_op = 4'($urandom); req1_src1 = $urandom; req1_src2 = $urandom;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !m_pend && !m_exec) break;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic got;
        int   lat;
        logic done0, done1;
        logic [3:0] rop;
        logic [31:0] ra, rb;

        // Reset held for 3 cycles with requester 0 already asking.
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd5; req0_src2 = 32'd7;
        req1_valid = 1'b0; req1_op = 4'd0; req1_src1 = 32'd0; req1_src2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_ready) begin got = 1'b1; break; end
        end
        chk("first_grant_req0", 32'(got), 32'd1);
        @(posedge clk); #1 req0_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
`ifdef ALU_ARB_FAST_EN
        chk("single_latency", 32'(lat), 32'd1);
`else
        chk("single_latency", 32'(lat), 32'd2);
`endif
        chk("single_res", resp_res, 32'd12);
        chk("single_zero", 32'(resp_zero), 32'd0);
        chk("single_id", 32'(resp_id), 32'd0);
        drain();

        // Contention: both always valid, grants must alternate.
        fork
            for (int i = 0; i < 4; i++) send0(OP_SUB, 32'd9, 32'd9);
            for (int i = 0; i < 4; i++) send1(OP_SRA, 32'h8000_0000, 32'd4);
        join
        drain();

        // Backpressure with requester 1 waiting.
        resp_ready = 1'b0;
        send0(OP_XOR, 32'h0000_00FF, 32'h0000_000F);
        fork
            send1(OP_SLTU, 32'd1, 32'd2);
            begin
                got = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    if (resp_valid) begin got = 1'b1; break; end
                end
                chk("bp_resp_seen", 32'(got), 32'd1);
                repeat (5) @(negedge clk);
                @(posedge clk); #1 resp_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of an op: the op must vanish, rr back to 0.
        send0(OP_ADD, 32'd1, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        fork
            send0(OP_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
            send1(OP_OR, 32'h1234_0000, 32'h0000_5678);
        join
        drain();

        // Unused encoding.
        send1(OP_BAD, 32'd3, 32'd4);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; break; end
        end
        chk("bad_resp_seen", 32'(got), 32'd1);
        chk("bad_res", resp_res, 32'd0);
        chk("bad_zero", 32'(resp_zero), 32'd0);
        drain();

        // Random traffic with random backpressure.
        done0 = 1'b0; done1 = 1'b0;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    rop = 4'($urandom_range(0, 15)); ra = $urandom;
                    rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                    send0(rop, ra, rb);
                end
                done0 = 1'b1;
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    logic [3:0] op1;
                    logic [31:0] a1, b1;
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    op1 = 4'($urandom_range(0, 15)); a1 = $urandom;
                    b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
                    send1(op1, a1, b1);
                end
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk); #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                resp_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
